// File: rtl/score_pkg.sv
// Shared constants and types for the score text renderer and its glyph ROM.
package score_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Glyph ROM address layout: digit in [7:4], row in [3:0].
    localparam int ADDR_DIGIT_LSB = 4;
    localparam int ADDR_ROW_LSB   = 0;

    function automatic logic [7:0] glyph_address(input bcd_digit_t digit, input logic [3:0] row);
        return {digit, row};
    endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Score/video/glyph-ROM signal bundle between the renderer and the surrounding video system.
interface score_renderer_if;

    logic       score_inc;
    logic       score_clr;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [7:0] glyph_addr;
    logic [7:0] glyph_data;
    logic       pixel_on;
    logic       score_sat;

    modport slave (
        input  score_inc, score_clr, hcount, vcount, glyph_data,
        output glyph_addr, pixel_on, score_sat
    );

    modport master (
        output score_inc, score_clr, hcount, vcount, glyph_data,
        input  glyph_addr, pixel_on, score_sat
    );

endinterface

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter; clear wins over increment.
module bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_sat
);
    import score_pkg::*;

    logic [4*DIGITS-1:0] r_value;
    logic [4*DIGITS-1:0] w_next;
    logic                w_sat;
    logic                w_carry;

    always_comb begin
        w_next  = r_value;
        w_sat   = 1'b1;
        w_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_value[4*i +: 4] != BCD_MAX) w_sat = 1'b0;
            if (w_carry) begin
                if (r_value[4*i +: 4] == BCD_MAX) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc && !w_sat) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;
    assign o_sat   = w_sat;

endmodule

// File: rtl/score_renderer.sv
// Renders the BCD score as glyph text: frame-stable shadow, box decode, and a
// 3-clock pixel pipeline around the external registered glyph ROM.
module score_renderer #(
    parameter int X0     = 16,
    parameter int Y0     = 16,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    score_renderer_if.slave    bus
);
    import score_pkg::*;

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + GLYPH_W * DIGITS);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + GLYPH_H);

    logic [4*DIGITS-1:0] w_count;
    logic [4*DIGITS-1:0] r_shadow;
    logic                w_in_box;
    logic [4:0]          w_dx;
    logic [1:0]          w_slot;
    logic [2:0]          w_col;
    logic [3:0]          w_row;
    bcd_digit_t          w_digit;
    logic [2:0]          w_bit_sel;

    logic [7:0]          r_glyph_addr;
    logic                r_in_box_d1;
    logic                r_in_box_d2;
    logic [2:0]          r_col_d1;
    logic [2:0]          r_col_d2;
    logic                r_pixel_on;

    bcd_counter #(.DIGITS(DIGITS)) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (bus.score_inc),
        .i_clr   (bus.score_clr),
        .o_value (w_count),
        .o_sat   (bus.score_sat)
    );

    // Loading at (0,0) sees the counter before any same-cycle increment lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (bus.hcount == 10'd0 && bus.vcount == 10'd0) begin
            r_shadow <= w_count;
        end
    end

    assign w_in_box = (bus.hcount >= X_LO) && (bus.hcount < X_HI) &&
                      (bus.vcount >= Y_LO) && (bus.vcount < Y_HI);
    assign w_dx     = 5'(bus.hcount - X_LO);
    assign w_slot   = w_dx[4:3];
    assign w_col    = w_dx[2:0];
    assign w_row    = 4'(bus.vcount - Y_LO);

    // Slot 0 is leftmost and shows the most significant digit.
    always_comb begin
        w_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(w_slot) == DIGITS - 1 - i) w_digit = r_shadow[4*i +: 4];
        end
    end

    assign w_bit_sel = 3'd7 - r_col_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glyph_addr <= '0;
            r_in_box_d1  <= 1'b0;
            r_in_box_d2  <= 1'b0;
            r_col_d1     <= '0;
            r_col_d2     <= '0;
            r_pixel_on   <= 1'b0;
        end else begin
            r_glyph_addr <= w_in_box ? glyph_address(w_digit, w_row) : 8'h00;
            r_in_box_d1  <= w_in_box;
            r_col_d1     <= w_col;
            r_in_box_d2  <= r_in_box_d1;
            r_col_d2     <= r_col_d1;
            r_pixel_on   <= r_in_box_d2 & bus.glyph_data[w_bit_sel];
        end
    end

    assign bus.glyph_addr = r_glyph_addr;
    assign bus.pixel_on   = r_pixel_on;

endmodule

// File: doc/score_renderer.md
# score_renderer

Draws the decimal game score as on-screen text. It keeps a saturating BCD score counter driven by game events, and it drives the address port of the existing digit glyph ROM. The ROM takes address {digit[3:0], row[3:0]} and returns a registered 8-bit row bitmap, MSB = leftmost pixel, with 1-cycle latency. The block serializes each returned row into a per-pixel `pixel_on` that the VGA colour mux ORs over the playfield.

## Interface
- `X0`, default 16: left edge of the score box, in pixels.
- `Y0`, default 16: top edge of the score box, in pixels.
- `DIGITS`, default 3: number of BCD digits displayed, range 1–4.

- `clk`  in  1  pixel clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `score_inc`  in  1  one-cycle pulse; adds 1 to the score.
- `score_clr`  in  1  one-cycle pulse; clears the score to 0.
- `hcount`  in  10  current pixel x coordinate from VGA timing.
- `vcount`  in  10  current pixel y coordinate from VGA timing.
- `glyph_addr`  out  8  glyph ROM address, {digit, row}; registered.
- `glyph_data`  in  8  glyph ROM row bitmap; valid 1 cycle after `glyph_addr`.
- `pixel_on`  out  1  score text pixel lit; registered.
- `score_sat`  out  1  high while the score is at its maximum, all digits 9.

## Operation
- **Score counter.** DIGITS BCD digits, least significant digit = digit 0.
  - `score_inc` increments the count, rippling the carry through 9→0 digit by digit.
  - At all-9s the counter holds its value, and `score_sat` is 1.
  - `score_clr` takes priority over `score_inc` when both are asserted in the same cycle; the result is 0 and `score_sat` is 0.
- **Display shadow.** Holds the value shown on screen, so the score never tears mid-frame.
  - Loads from the counter on the cycle where hcount==0 and vcount==0.
  - If that load coincides with an increment, it captures the pre-increment count.
- **Box decode** on the sampled coordinates:
  - in_box = (X0 ≤ hcount < X0+8·DIGITS) and (Y0 ≤ vcount < Y0+16).
  - dx = hcount−X0, dy = vcount−Y0.
  - Digit slot = dx[..:3], with slot 0 the leftmost, showing the most significant digit.
  - col = dx[2:0], row = dy[3:0].
- **Glyph address.** When in_box, `glyph_addr` = {shadow digit for the slot, row}; when not in_box, `glyph_addr` = 8'h00.
- **Leading zeros** are displayed, e.g. score 7 shows "007".
- **Pixel output.** `pixel_on` = in_box delayed 2 cycles AND glyph_data[7 − (col delayed 2)].
  - Rows 10–15 of every glyph are blank in the ROM, so no extra masking is needed.
- Comparisons are unsigned and 10 bits wide. Coordinates left of X0 or above Y0 are out of box; no wrap-around.

## Timing
- **Reset values.** Asserting `rst_n` low, even mid-frame or mid-increment, immediately forces:
  - counter = 0, shadow = 0, `score_sat` = 0;
  - `glyph_addr` = 0, all pipeline valid and col registers = 0, `pixel_on` = 0.
- **Pixel pipeline, for coordinates sampled at edge N:**
  - Edge N: `glyph_addr`, in_box_d1 and col_d1 are registered.
  - Edge N+1: the ROM registers `glyph_data`; in_box_d2 and col_d2 are registered.
  - Edge N+2: `pixel_on` updates. Latency is 3 clocks, and the VGA sync/blank path is delayed to match.
- **Score update.** The counter updates 1 cycle after a `score_inc` or `score_clr` pulse. The change becomes visible on screen from the next frame, at the next (0,0) shadow load.
- Back-to-back `score_inc` pulses in consecutive cycles each count.
- No handshake on `score_inc` or `score_clr`; every asserted cycle is one event.

## Structure
- **Shared package `score_pkg`** holds:
  - GLYPH_W = 8, GLYPH_H = 16;
  - the `bcd_digit_t` type (4 bits);
  - the glyph ROM address layout: digit field [7:4], row field [3:0].
- **Sub-module `bcd_counter`**, parameterized by DIGITS, with inc, clr and sat. It owns the saturation and clear-priority rules.
- `score_renderer` holds the shadow register, the box decode and the 3-stage pixel pipeline.
- The glyph ROM stays external, wired at the top level.

## Test plan
- **Reset value.** Reset, then scan one frame over the box with a behavioural ROM model → `pixel_on` pattern equals the "000" glyph rows, shifted 3 clocks; `score_sat` = 0.
- **Carry ripple.** 129 `score_inc` pulses, then wait for the next frame → `glyph_addr` in box row 4 is 8'h14, then 8'h24, then 8'h94; the display shows "129".
- **Saturation.** 1005 pulses with DIGITS=3 → counter holds 999; `score_sat` = 1 from the 999th pulse; a further pulse leaves 999.
- **Clear priority.** `score_inc` and `score_clr` asserted in the same cycle at score 42 → counter 0 next cycle, `score_sat` 0.
- **No tearing.** Increment at mid-frame (vcount = 200) → the displayed digits change only after the next (0,0) load.
- **Box edges and async reset.**
  - hcount = X0−1, X0+8·DIGITS and vcount = Y0+16 → `pixel_on` 0, `glyph_addr` 0.
  - `rst_n` pulsed low mid-line → `pixel_on` 0 immediately, with no clock edge needed.
